note_sequencer: RTL and testbench

Plays a stored melody by driving the 14-bit frequency input of the sine signal generator, one note at a time.
- Each song entry holds a frequency and a duration; the block holds each frequency for its duration, then inserts a silent gap.
- It sits directly upstream of the signal generator: its `outputFrequency` wires to the generator's `inputFrequency`, and both run on the same 32 kHz clock.
- Start/stop control comes from the music-box top level.

---
 rtl/note_sequencer.sv | 172 +++++++++++++++++
 tb/tb_note_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody player feeding the sine generator: walks a song ROM, holding each
// clamped frequency for its duration followed by a silent gap.
module note_sequencer #(
    parameter int TICKS_PER_UNIT = 4000,
    parameter int GAP_TICKS      = 320,
    parameter int SONG_LENGTH    = 32,
    parameter int TEST_SONG      = 0
) (
    input  logic        CLK_32KHz,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [13:0] outputFrequency,
    output logic        noteActive,
    output logic        busy,
    output logic        done,
    output logic [5:0]  noteIndex
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [6:0]  r_index;
    logic [17:0] r_ticks;

    logic [17:0] w_romWord;
    logic [13:0] w_romFreq;
    logic [3:0]  w_romDur;
    logic [13:0] w_clampFreq;
    logic [17:0] w_noteTicks;
    logic        w_atEnd;
    logic        w_endOfSong;
    logic [6:0]  w_nextIndex;

    // Song table: the fixed test melody, or a generated pentatonic-style phrase
    // whose lower octave is used on every second group of eight entries.
    function automatic logic [17:0] songEntry(input logic [6:0] idx);
        logic [13:0] f;
        logic [3:0]  d;
        f = '0;
        d = '0;
        if (TEST_SONG != 0) begin
            case (idx)
                7'd0:    begin f = 14'd440;   d = 4'd2; end
                7'd1:    begin f = 14'd0;     d = 4'd1; end
                7'd2:    begin f = 14'd12000; d = 4'd1; end
                7'd3:    begin f = 14'd50;    d = 4'd1; end
                default: begin f = 14'd0;     d = 4'd0; end
            endcase
        end else begin
            case (idx[2:0])
                3'd0:    f = 14'd523;
                3'd1:    f = 14'd587;
                3'd2:    f = 14'd659;
                3'd3:    f = 14'd784;
                3'd4:    f = 14'd880;
                3'd5:    f = 14'd784;
                3'd6:    f = 14'd659;
                default: f = 14'd587;
            endcase
            if (idx[3]) f = f >> 1;
            d = {2'b00, idx[1:0]} + 4'd1;
            if (idx[6:4] == 3'd7) d = 4'd0;
        end
        return {f, d};
    endfunction

    always_comb begin
        w_romWord = songEntry(r_index);
        w_romFreq = w_romWord[17:4];
        w_romDur  = w_romWord[3:0];
        if (w_romFreq > 14'd8000)
            w_clampFreq = 14'd8000;
        else if (w_romFreq != 14'd0 && w_romFreq < 14'd100)
            w_clampFreq = 14'd100;
        else
            w_clampFreq = w_romFreq;
        w_noteTicks = ({14'd0, w_romDur} * 18'(TICKS_PER_UNIT)) - 18'd1;
        w_atEnd     = (r_index >= 7'(SONG_LENGTH));
        w_endOfSong = w_atEnd || (w_romDur == 4'd0);
        w_nextIndex = w_atEnd ? r_index : r_index + 7'd1;
    end

    assign noteIndex = r_index[5:0];

    // Outputs are set on state transitions so each one is a plain register;
    // stop overrides everything and returns the block to a silent idle.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_index         <= '0;
            r_ticks         <= '0;
            outputFrequency <= '0;
            noteActive      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (stop) begin
            r_state         <= S_IDLE;
            r_index         <= '0;
            r_ticks         <= '0;
            outputFrequency <= '0;
            noteActive      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_index <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_endOfSong) begin
                        if (loop_en) begin
                            r_index <= '0;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        outputFrequency <= w_clampFreq;
                        noteActive      <= (w_clampFreq != 14'd0);
                        r_ticks         <= w_noteTicks;
                        r_state         <= S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (r_ticks == 18'd0) begin
                        outputFrequency <= '0;
                        noteActive      <= 1'b0;
                        if (GAP_TICKS == 0) begin
                            r_index <= w_nextIndex;
                            r_state <= S_LOAD;
                        end else begin
                            r_ticks <= 18'(GAP_TICKS - 1);
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_ticks <= r_ticks - 18'd1;
                    end
                end
                S_GAP: begin
                    if (r_ticks == 18'd0) begin
                        r_index <= w_nextIndex;
                        r_state <= S_LOAD;
                    end else begin
                        r_ticks <= r_ticks - 18'd1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_index <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a song-level model expands the test
// table into a per-cycle trace that a negedge monitor compares against.
module tb_note_sequencer;

    localparam int T = 4;
    localparam int G = 2;

    logic        CLK_32KHz;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [13:0] outputFrequency;
    logic        noteActive;
    logic        busy;
    logic        done;
    logic [5:0]  noteIndex;

    typedef struct {
        int  freq;
        bit  active;
        bit  busy;
        bit  done;
        int  idx;
        bit  idxCare;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   sampleNo = 0;

    int songFreq[5] = '{440, 0, 12000, 50, 0};
    int songDur[5]  = '{2, 1, 1, 1, 0};

    note_sequencer #(
        .TICKS_PER_UNIT(T),
        .GAP_TICKS(G),
        .SONG_LENGTH(32),
        .TEST_SONG(1)
    ) dut (
        .CLK_32KHz(CLK_32KHz),
        .reset_n(reset_n),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .outputFrequency(outputFrequency),
        .noteActive(noteActive),
        .busy(busy),
        .done(done),
        .noteIndex(noteIndex)
    );

    initial CLK_32KHz = 1'b0;
    always #5 CLK_32KHz = ~CLK_32KHz;

    function automatic exp_t mk(int f, bit a, bit b, bit d, int i, bit care);
        exp_t s;
        s.freq = f; s.active = a; s.busy = b; s.done = d; s.idx = i; s.idxCare = care;
        return s;
    endfunction

    function automatic int clampHz(int f);
        if (f > 8000) return 8000;
        if (f >= 1 && f <= 99) return 100;
        return f;
    endfunction

    // Expands the song into one expected sample per cycle after start is taken,
    // then silences everything from the cycle where stop is taken.
    function automatic void buildTrace(bit loopEn, int len, int stopAt);
        exp_t t[$];
        exp_t idle;
        int e;
        int f;
        int d;
        idle = mk(0, 0, 0, 0, 0, 1);
        e = 0;
        while (t.size() < len) begin
            f = (e < 5) ? songFreq[e] : 0;
            d = (e < 5) ? songDur[e] : 0;
            t.push_back(mk(0, 0, 1, 0, e, 1));
            if (d == 0) begin
                if (loopEn) e = 0;
                else begin
                    t.push_back(mk(0, 0, 1, 1, 0, 0));
                    break;
                end
            end else begin
                f = clampHz(f);
                repeat (d * T) t.push_back(mk(f, f != 0, 1, 0, e, 1));
                repeat (G) t.push_back(mk(0, 0, 1, 0, e, 1));
                e++;
            end
        end
        while (t.size() < len) t.push_back(idle);
        expQ.push_back(idle);
        for (int c = 0; c < len; c++) begin
            if (stopAt > 0 && c >= stopAt) expQ.push_back(idle);
            else expQ.push_back(t[c]);
        end
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        bit ok;
        ok = (int'(outputFrequency) == e.freq) && (noteActive == e.active) &&
             (busy == e.busy) && (done == e.done) &&
             (!e.idxCare || int'(noteIndex) == e.idx);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got freq=%0d act=%0b busy=%0b done=%0b idx=%0d, expected freq=%0d act=%0b busy=%0b done=%0b idx=%0d(care=%0b)",
                     name, outputFrequency, noteActive, busy, done, noteIndex,
                     e.freq, e.active, e.busy, e.done, e.idx, e.idxCare);
        end
    endtask

    // Monitor: one expected sample is consumed per falling edge while any are queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK_32KHz);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                sampleNo++;
                checkOutput($sformatf("sample%0d", sampleNo), e);
            end
        end
    end

    // Drives one playback run; start is taken at the edge after the call.
    task automatic applyStimulus(input bit loopEn, input int stopAt,
                                 input int extraStartAt, input bit startWithStop,
                                 input int runCycles);
        @(posedge CLK_32KHz);
        #2;
        start   = 1'b1;
        loop_en = loopEn;
        buildTrace(loopEn, runCycles, stopAt);
        for (int c = 0; c < runCycles; c++) begin
            @(posedge CLK_32KHz);
            #2;
            start = 1'b0;
            stop  = 1'b0;
            if (stopAt == c + 1) begin
                stop  = 1'b1;
                start = startWithStop;
            end
            if (extraStartAt == c + 1) start = 1'b1;
        end
        for (int w = 0; w < 200 && expQ.size() > 0; w++) @(posedge CLK_32KHz);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d samples left, required 0", expQ.size());
            expQ.delete();
        end
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
    endtask

    initial begin
        bit lp;
        int sa;
        int xs;
        int rc;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        #13;
        checkOutput("reset_state", mk(0, 0, 0, 0, 0, 1));
        #10;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of the first note.
        @(posedge CLK_32KHz); #2; start = 1'b1;
        @(posedge CLK_32KHz); #2; start = 1'b0;
        repeat (4) @(posedge CLK_32KHz);
        #2;
        checkOutput("pre_reset_note", mk(440, 1, 1, 0, 0, 1));
        #1 reset_n = 1'b0;
        #1 checkOutput("async_reset", mk(0, 0, 0, 0, 0, 1));
        #20 reset_n = 1'b1;

        $display("[TB] single play");
        applyStimulus(1'b0, 0, 0, 1'b0, 40);
        $display("[TB] start while busy (gap)");
        applyStimulus(1'b0, 0, 10, 1'b0, 40);
        $display("[TB] stop during 8000 Hz with start");
        applyStimulus(1'b0, 21, 0, 1'b1, 30);
        $display("[TB] loop");
        applyStimulus(1'b1, 75, 0, 1'b0, 78);

        for (int r = 0; r < 10; r++) begin
            lp = 1'($urandom_range(0, 1));
            if (lp) begin
                sa = $urandom_range(35, 90);
                rc = sa + 3;
            end else begin
                sa = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 33) : 0;
                rc = 40;
            end
            xs = $urandom_range(1, (sa > 0) ? sa - 1 : 33);
            applyStimulus(lp, sa, xs, 1'($urandom_range(0, 1)), rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
